// File: rtl/count_delay_line.sv
// count_delay_line: up/down counter with a DEPTH-stage registered history of
// its past values. Counter priority per edge is clr > load > en > hold.
// Optional feature macro: COUNT_DELAY_SAT_EN compiles in saturate mode
// (selected per cycle by sat) and makes sat_hit live; without it the counter
// always wraps, sat is ignored and sat_hit is tied low.

module count_delay_line #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned STEP  = 1
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   clr,
  input  logic                   load,
  input  logic [WIDTH-1:0]       load_val,
  input  logic                   en,
  input  logic                   up,
  input  logic                   sat,
  output logic [WIDTH-1:0]       count,
  output logic [DEPTH*WIDTH-1:0] tap,
  output logic [DEPTH-1:0]       tap_vld,
  output logic                   wrap,
  output logic                   sat_hit
);

  localparam int unsigned EXT_W = WIDTH + 1;
  localparam int unsigned TAP_W = DEPTH * WIDTH;
  localparam logic [WIDTH:0] STEP_EXT = EXT_W'(STEP);

  logic [WIDTH:0]   sum_up;
  logic [WIDTH:0]   sum_dn;
  logic             ovf;
  logic [WIDTH-1:0] adv;
  logic [WIDTH-1:0] count_nxt;
  logic             wrap_nxt;
  logic [TAP_W-1:0] tap_shift;
  logic [DEPTH-1:0] tap_vld_shift;

  // Step arithmetic at WIDTH+1 bits; the top bit flags overflow/underflow
  always_comb begin
    sum_up = {1'b0, count} + STEP_EXT;
    sum_dn = {1'b0, count} - STEP_EXT;
    ovf    = up ? sum_up[WIDTH] : sum_dn[WIDTH];
    adv    = up ? sum_up[WIDTH-1:0] : sum_dn[WIDTH-1:0];
  end

`ifdef COUNT_DELAY_SAT_EN
  logic             sat_hit_nxt;
  logic [WIDTH-1:0] limit;

  // Next count with priority clr > load > en; clamp or wrap on overflow
  always_comb begin
    count_nxt   = count;
    wrap_nxt    = 1'b0;
    sat_hit_nxt = 1'b0;
    limit       = up ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
    if (clr) begin
      count_nxt = '0;
    end else if (load) begin
      count_nxt = load_val;
    end else if (en) begin
      count_nxt = adv;
      if (ovf) begin
        if (sat) begin
          count_nxt   = limit;
          sat_hit_nxt = 1'b1;
        end else begin
          wrap_nxt = 1'b1;
        end
      end
    end
  end

  // Saturation pulse register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sat_hit <= 1'b0;
    end else begin
      sat_hit <= sat_hit_nxt;
    end
  end
`else
  // sat has no effect in the wrap-only build
  logic sat_unused;
  assign sat_unused = sat;
  assign sat_hit    = 1'b0;

  // Next count with priority clr > load > en; always wraps on overflow
  always_comb begin
    count_nxt = count;
    wrap_nxt  = 1'b0;
    if (clr) begin
      count_nxt = '0;
    end else if (load) begin
      count_nxt = load_val;
    end else if (en) begin
      count_nxt = adv;
      wrap_nxt  = ovf;
    end
  end
`endif

  // History shift: tap0 takes the registered count, tap k takes tap k-1
  for (genvar k = 0; k < int'(DEPTH); k++) begin : g_hist
    if (k == 0) begin : g_head
      assign tap_shift[WIDTH-1:0] = count;
    end else begin : g_body
      assign tap_shift[k*WIDTH +: WIDTH] = tap[(k-1)*WIDTH +: WIDTH];
    end
  end

  // Valid flags shift left with a 1 entering at bit 0
  assign tap_vld_shift = DEPTH'({tap_vld, 1'b1});

  // Counter, wrap pulse and history registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count   <= '0;
      wrap    <= 1'b0;
      tap     <= '0;
      tap_vld <= '0;
    end else begin
      count <= count_nxt;
      wrap  <= wrap_nxt;
      if (clr) begin
        tap     <= '0;
        tap_vld <= '0;
      end else begin
        tap     <= tap_shift;
        tap_vld <= tap_vld_shift;
      end
    end
  end

endmodule

// File: tb/tb_count_delay_line.sv
// Directed, table-driven bench for count_delay_line: a STEP=1 instance and a
// STEP=3 instance (both WIDTH=8, DEPTH=4) checked against hand-computed values.

module tb_count_delay_line;

  logic        clk;
  logic        n_rst;

  logic        a_clr, a_load, a_en, a_up, a_sat;
  logic [7:0]  a_load_val;
  logic [7:0]  a_count;
  logic [31:0] a_tap;
  logic [3:0]  a_tap_vld;
  logic        a_wrap, a_sat_hit;

  logic        b_clr, b_load, b_en, b_up, b_sat;
  logic [7:0]  b_load_val;
  logic [7:0]  b_count;
  logic [31:0] b_tap;
  logic [3:0]  b_tap_vld;
  logic        b_wrap, b_sat_hit;

  count_delay_line dut (
    .clk(clk), .n_rst(n_rst), .clr(a_clr), .load(a_load), .load_val(a_load_val),
    .en(a_en), .up(a_up), .sat(a_sat), .count(a_count), .tap(a_tap),
    .tap_vld(a_tap_vld), .wrap(a_wrap), .sat_hit(a_sat_hit)
  );

  count_delay_line #(.STEP(3)) dut3 (
    .clk(clk), .n_rst(n_rst), .clr(b_clr), .load(b_load), .load_val(b_load_val),
    .en(b_en), .up(b_up), .sat(b_sat), .count(b_count), .tap(b_tap),
    .tap_vld(b_tap_vld), .wrap(b_wrap), .sat_hit(b_sat_hit)
  );

  typedef struct {
    logic        use3;
    logic        clr;
    logic        load;
    logic [7:0]  load_val;
    logic        en;
    logic        up;
    logic        sat;
    logic [7:0]  exp_count;
    logic        chk_tap;
    logic [31:0] exp_tap;
    logic [3:0]  exp_vld;
    logic        exp_wrap;
    logic        exp_sat;
  } vec_t;

  vec_t vecs [40];
  int   num_vec;
  int   n_vec;
  int   n_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t v(input logic u3, input logic c, input logic l,
                             input logic [7:0] lv, input logic e, input logic u,
                             input logic s, input logic [7:0] ec, input logic ct,
                             input logic [31:0] et, input logic [3:0] ev,
                             input logic ew, input logic es);
    vec_t r;
    r.use3 = u3; r.clr = c; r.load = l; r.load_val = lv; r.en = e; r.up = u;
    r.sat = s; r.exp_count = ec; r.chk_tap = ct; r.exp_tap = et; r.exp_vld = ev;
    r.exp_wrap = ew; r.exp_sat = es;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    a_clr = 0; a_load = 0; a_load_val = 0; a_en = 0; a_up = 0; a_sat = 0;
    b_clr = 0; b_load = 0; b_load_val = 0; b_en = 0; b_up = 0; b_sat = 0;
  endtask

  task automatic run_vec(input int i);
    vec_t r;
    r = vecs[i];
    idle_inputs();
    if (r.use3) begin
      b_clr = r.clr; b_load = r.load; b_load_val = r.load_val;
      b_en = r.en; b_up = r.up; b_sat = r.sat;
    end else begin
      a_clr = r.clr; a_load = r.load; a_load_val = r.load_val;
      a_en = r.en; a_up = r.up; a_sat = r.sat;
    end
    @(posedge clk);
    #1;
    if (r.use3) begin
      chk($sformatf("v%0d count", i), 32'(b_count), 32'(r.exp_count));
      if (r.chk_tap) chk($sformatf("v%0d tap", i), b_tap, r.exp_tap);
      chk($sformatf("v%0d tap_vld", i), 32'(b_tap_vld), 32'(r.exp_vld));
      chk($sformatf("v%0d wrap", i), 32'(b_wrap), 32'(r.exp_wrap));
      chk($sformatf("v%0d sat_hit", i), 32'(b_sat_hit), 32'(r.exp_sat));
    end else begin
      chk($sformatf("v%0d count", i), 32'(a_count), 32'(r.exp_count));
      if (r.chk_tap) chk($sformatf("v%0d tap", i), a_tap, r.exp_tap);
      chk($sformatf("v%0d tap_vld", i), 32'(a_tap_vld), 32'(r.exp_vld));
      chk($sformatf("v%0d wrap", i), 32'(a_wrap), 32'(r.exp_wrap));
      chk($sformatf("v%0d sat_hit", i), 32'(a_sat_hit), 32'(r.exp_sat));
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    // STEP=1 instance: counting, up wrap, down wrap, clr priority, valid fill
    //            u3 clr ld lval en up sat cnt  ct tap           vld  w  s
    vecs[0]  = v(0, 0, 0, 8'd0,   1, 1, 0, 8'd1,   1, 32'h00000000, 4'h1, 0, 0);
    vecs[1]  = v(0, 0, 0, 8'd0,   1, 1, 0, 8'd2,   1, 32'h00000001, 4'h3, 0, 0);
    vecs[2]  = v(0, 0, 0, 8'd0,   1, 1, 0, 8'd3,   1, 32'h00000102, 4'h7, 0, 0);
    vecs[3]  = v(0, 0, 0, 8'd0,   1, 1, 0, 8'd4,   1, 32'h00010203, 4'hf, 0, 0);
    vecs[4]  = v(0, 0, 1, 8'd254, 1, 1, 0, 8'd254, 1, 32'h01020304, 4'hf, 0, 0);
    vecs[5]  = v(0, 0, 0, 8'd0,   1, 1, 0, 8'd255, 1, 32'h020304fe, 4'hf, 0, 0);
    vecs[6]  = v(0, 0, 0, 8'd0,   1, 1, 0, 8'd0,   1, 32'h0304feff, 4'hf, 1, 0);
    vecs[7]  = v(0, 0, 0, 8'd0,   0, 1, 0, 8'd0,   1, 32'h04feff00, 4'hf, 0, 0);
    vecs[8]  = v(0, 0, 0, 8'd0,   1, 0, 0, 8'd255, 1, 32'hfeff0000, 4'hf, 1, 0);
    vecs[9]  = v(0, 0, 0, 8'd0,   1, 0, 0, 8'd254, 1, 32'hff0000ff, 4'hf, 0, 0);
    vecs[10] = v(0, 1, 1, 8'd99,  1, 1, 0, 8'd0,   1, 32'h00000000, 4'h0, 0, 0);
    vecs[11] = v(0, 0, 1, 8'd7,   0, 0, 0, 8'd7,   1, 32'h00000000, 4'h1, 0, 0);
    vecs[12] = v(0, 0, 0, 8'd0,   1, 1, 0, 8'd8,   1, 32'h00000007, 4'h3, 0, 0);
    vecs[13] = v(0, 0, 0, 8'd0,   1, 0, 1, 8'd7,   1, 32'h00000708, 4'h7, 0, 0);
    vecs[14] = v(0, 0, 0, 8'd0,   0, 0, 0, 8'd7,   1, 32'h00070807, 4'hf, 0, 0);
    // STEP=3 instance: priority, load, step, wrap through 0 both ways
    vecs[15] = v(1, 0, 1, 8'd10,  0, 0, 0, 8'd10,  1, 32'h00000000, 4'h3, 0, 0);
    vecs[16] = v(1, 1, 1, 8'd99,  1, 1, 0, 8'd0,   1, 32'h00000000, 4'h0, 0, 0);
    vecs[17] = v(1, 0, 1, 8'd99,  0, 0, 0, 8'd99,  1, 32'h00000000, 4'h1, 0, 0);
    vecs[18] = v(1, 0, 0, 8'd0,   1, 1, 0, 8'd102, 1, 32'h00000063, 4'h3, 0, 0);
    vecs[19] = v(1, 0, 1, 8'd253, 1, 1, 0, 8'd253, 1, 32'h00006366, 4'h7, 0, 0);
    vecs[20] = v(1, 0, 0, 8'd0,   1, 1, 0, 8'd0,   1, 32'h006366fd, 4'hf, 1, 0);
    vecs[21] = v(1, 0, 0, 8'd0,   1, 0, 0, 8'd253, 1, 32'h6366fd00, 4'hf, 1, 0);
    vecs[22] = v(1, 0, 0, 8'd0,   1, 0, 0, 8'd250, 1, 32'h66fd00fd, 4'hf, 0, 0);
`ifdef COUNT_DELAY_SAT_EN
    // Saturate mode on the STEP=1 instance
    vecs[23] = v(0, 1, 0, 8'd0,   0, 0, 0, 8'd0,   1, 32'h00000000, 4'h0, 0, 0);
    vecs[24] = v(0, 0, 0, 8'd0,   1, 0, 1, 8'd0,   0, 32'h0,        4'h1, 0, 1);
    vecs[25] = v(0, 0, 1, 8'd255, 0, 0, 1, 8'd255, 0, 32'h0,        4'h3, 0, 0);
    vecs[26] = v(0, 0, 0, 8'd0,   1, 1, 1, 8'd255, 0, 32'h0,        4'h7, 0, 1);
    vecs[27] = v(0, 0, 0, 8'd0,   1, 1, 1, 8'd255, 0, 32'h0,        4'hf, 0, 1);
    vecs[28] = v(0, 0, 0, 8'd0,   1, 1, 0, 8'd0,   0, 32'h0,        4'hf, 1, 0);
    vecs[29] = v(0, 0, 0, 8'd0,   0, 1, 1, 8'd0,   0, 32'h0,        4'hf, 0, 0);
    num_vec = 30;
`else
    // Wrap-only build: sat must have no effect
    vecs[23] = v(0, 1, 0, 8'd0,   0, 0, 0, 8'd0,   1, 32'h00000000, 4'h0, 0, 0);
    vecs[24] = v(0, 0, 0, 8'd0,   1, 0, 1, 8'd255, 1, 32'h00000000, 4'h1, 1, 0);
    vecs[25] = v(0, 0, 0, 8'd0,   1, 1, 1, 8'd0,   1, 32'h000000ff, 4'h3, 1, 0);
    num_vec = 26;
`endif

    idle_inputs();
    n_rst = 1'b1;
    #2 n_rst = 1'b0;
    #10;
    chk("reset count", 32'(a_count), 32'd0);
    chk("reset tap", a_tap, 32'd0);
    chk("reset tap_vld", 32'(a_tap_vld), 32'd0);
    chk("reset wrap", 32'(a_wrap), 32'd0);
    chk("reset sat_hit", 32'(a_sat_hit), 32'd0);
    @(negedge clk);
    n_rst = 1'b1;

    for (int i = 0; i < 15; i++) run_vec(i);

    // Asynchronous reset between edges while count=7
    #2 n_rst = 1'b0;
    #1;
    chk("midrst count", 32'(a_count), 32'd0);
    chk("midrst tap", a_tap, 32'd0);
    chk("midrst tap_vld", 32'(a_tap_vld), 32'd0);
    chk("midrst wrap", 32'(a_wrap), 32'd0);
    chk("midrst sat_hit", 32'(a_sat_hit), 32'd0);
    idle_inputs();
    a_en = 1'b1;
    a_up = 1'b1;
    @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk);
    #1;
    chk("release count", 32'(a_count), 32'd1);
    chk("release tap0", 32'(a_tap[7:0]), 32'd0);
    chk("release tap_vld", 32'(a_tap_vld), 32'd1);

    for (int i = 15; i < num_vec; i++) run_vec(i);

    idle_inputs();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
